// File: rtl/edubos5_alu_issue.sv
// ---------------------------------------------------------------------------
// edubos5_alu_issue
//
// Operand-issue and result-capture stage around the eduBOS5 RV32I ALU.
// A decoded ALU / OP-IMM / branch / JALR request is taken over a valid/ready
// handshake. The stage then drives the ALU operand and control inputs and
// waits out the ALU's registered latency. It captures the ALU result and
// comparison flags, resolves the branch decision and offers a writeback
// response over a second valid/ready handshake.
//
// Parameters:
//   ALU_LAT       ALU clock edges from operand drive to valid result (1..4)
//
// Ports:
//   clk, reset    system clock, asynchronous active-high reset
//   req_*         decoded request (valid/ready handshake, ready is output)
//   aluin_1/2     ALU operands
//   shamt         ALU shift amount
//   alu_funct3    ALU funct3
//   alu_funct7_5  ALU funct7_5
//   aluimm_dec    ALU OP-IMM select
//   jalr_dec      ALU JALR select
//   alu_out       ALU result (input)
//   eq, lt, ltu   ALU comparison flags (inputs)
//   rsp_*         writeback response (valid/ready handshake, ready is input)
// ---------------------------------------------------------------------------
module edubos5_alu_issue #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    // request side
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [31:0] req_imm,
    input  logic        req_aluimm,
    input  logic        req_jalr,
    input  logic        req_branch,
    input  logic [2:0]  req_funct3,
    input  logic        req_funct7_5,
    input  logic [4:0]  req_rd,
    // ALU-facing side
    output logic [31:0] aluin_1,
    output logic [31:0] aluin_2,
    output logic [4:0]  shamt,
    output logic [2:0]  alu_funct3,
    output logic        alu_funct7_5,
    output logic        aluimm_dec,
    output logic        jalr_dec,
    input  logic [31:0] alu_out,
    input  logic        eq,
    input  logic        lt,
    input  logic        ltu,
    // response side
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_we,
    output logic        rsp_br_taken
);

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    // Counter preload: number of WAIT cycles before the capture cycle.
    // ALU_LAT is limited to 1..4, so two bits are enough.
    localparam logic [1:0] CNT_INIT = 2'(ALU_LAT - 1);

    // Branch decision from the ALU flags, indexed by funct3.
    function automatic logic branch_taken(
        input logic [2:0] f3,
        input logic       f_eq,
        input logic       f_lt,
        input logic       f_ltu
    );
        logic tk;
        case (f3)
            3'b000:  tk = f_eq;
            3'b001:  tk = ~f_eq;
            3'b100:  tk = f_lt;
            3'b101:  tk = ~f_lt;
            3'b110:  tk = f_ltu;
            3'b111:  tk = ~f_ltu;
            default: tk = 1'b0;
        endcase
        return tk;
    endfunction

    // state and control registers
    logic [1:0]  r_state;
    logic [1:0]  r_cnt;
    logic        r_idle_rdy;

    // ALU-facing registers (loaded at accept, held until capture)
    logic [31:0] r_aluin_1;
    logic [31:0] r_aluin_2;
    logic [4:0]  r_shamt;
    logic [2:0]  r_alu_funct3;
    logic        r_alu_funct7_5;
    logic        r_aluimm_dec;
    logic        r_jalr_dec;

    // op registers needed at capture time
    logic        r_branch;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;

    // response registers
    logic [31:0] r_rsp_data;
    logic [4:0]  r_rsp_rd;
    logic        r_rsp_we;
    logic        r_rsp_br_taken;

    // combinational helpers
    logic [1:0]  w_state_nxt;
    logic        w_accept;
    logic        w_capture;
    logic        w_jalr_eff;
    logic [31:0] w_rsp_data;
    logic        w_rsp_we;
    logic        w_rsp_br_taken;

    // Ready is 1 in IDLE (only once out of reset) and follows rsp_ready in
    // RESP, so a new request can slip in on the same edge the response leaves.
    assign req_ready = r_idle_rdy | ((r_state == S_RESP) & rsp_ready);
    assign w_accept  = req_valid & req_ready;
    assign w_capture = (r_state == S_WAIT) & (r_cnt == 2'd0);

    // Branch wins over JALR when a decoder flags both.
    assign w_jalr_eff = req_jalr & ~req_branch;

    assign aluin_1      = r_aluin_1;
    assign aluin_2      = r_aluin_2;
    assign shamt        = r_shamt;
    assign alu_funct3   = r_alu_funct3;
    assign alu_funct7_5 = r_alu_funct7_5;
    assign aluimm_dec   = r_aluimm_dec;
    assign jalr_dec     = r_jalr_dec;

    assign rsp_valid    = (r_state == S_RESP);
    assign rsp_data     = r_rsp_data;
    assign rsp_rd       = r_rsp_rd;
    assign rsp_we       = r_rsp_we;
    assign rsp_br_taken = r_rsp_br_taken;

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_EXEC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_EXEC: begin
                // WAIT doubles as the capture cycle when ALU_LAT is 1
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 2'd0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    if (w_accept) begin
                        w_state_nxt = S_EXEC;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Response values formed from the ALU result at capture time
    always_comb begin
        w_rsp_data     = alu_out;
        w_rsp_we       = 1'b0;
        w_rsp_br_taken = 1'b0;
        if (r_branch) begin
            w_rsp_data     = alu_out;
            w_rsp_we       = 1'b0;
            w_rsp_br_taken = branch_taken(r_funct3, eq, lt, ltu);
        end else if (r_jalr_dec) begin
            // jump target is always halfword aligned; link write is done later
            w_rsp_data     = {alu_out[31:1], 1'b0};
            w_rsp_we       = 1'b0;
            w_rsp_br_taken = 1'b0;
        end else begin
            w_rsp_data     = alu_out;
            w_rsp_we       = (r_rd != 5'd0);
            w_rsp_br_taken = 1'b0;
        end
    end

    // FSM state, latency counter and idle-ready flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 2'd0;
            r_idle_rdy <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idle_rdy <= (w_state_nxt == S_IDLE);
            if (r_state == S_EXEC) begin
                r_cnt <= CNT_INIT;
            end else if ((r_state == S_WAIT) && (r_cnt != 2'd0)) begin
                r_cnt <= r_cnt - 2'd1;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Op registers: operand mapping applied once at accept, then held
    // unchanged so the ALU output stage sees stable controls until capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_aluin_1      <= 32'd0;
            r_aluin_2      <= 32'd0;
            r_shamt        <= 5'd0;
            r_alu_funct3   <= 3'd0;
            r_alu_funct7_5 <= 1'b0;
            r_aluimm_dec   <= 1'b0;
            r_jalr_dec     <= 1'b0;
            r_branch       <= 1'b0;
            r_funct3       <= 3'd0;
            r_rd           <= 5'd0;
        end else if (w_accept) begin
            r_aluin_1      <= req_rs1;
            r_aluin_2      <= (req_aluimm | w_jalr_eff) ? req_imm : req_rs2;
            r_shamt        <= req_aluimm ? req_imm[4:0] : req_rs2[4:0];
            r_alu_funct3   <= (req_branch | w_jalr_eff) ? 3'b000 : req_funct3;
            // branches subtract for the compare; JALR must add
            if (req_branch) begin
                r_alu_funct7_5 <= 1'b1;
            end else if (w_jalr_eff) begin
                r_alu_funct7_5 <= 1'b0;
            end else begin
                r_alu_funct7_5 <= req_funct7_5;
            end
            r_aluimm_dec   <= req_aluimm;
            r_jalr_dec     <= w_jalr_eff;
            r_branch       <= req_branch;
            r_funct3       <= req_funct3;
            r_rd           <= req_rd;
        end else begin
            r_aluin_1      <= r_aluin_1;
            r_aluin_2      <= r_aluin_2;
            r_shamt        <= r_shamt;
            r_alu_funct3   <= r_alu_funct3;
            r_alu_funct7_5 <= r_alu_funct7_5;
            r_aluimm_dec   <= r_aluimm_dec;
            r_jalr_dec     <= r_jalr_dec;
            r_branch       <= r_branch;
            r_funct3       <= r_funct3;
            r_rd           <= r_rd;
        end
    end

    // Response registers: written only in the capture cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_data     <= 32'd0;
            r_rsp_rd       <= 5'd0;
            r_rsp_we       <= 1'b0;
            r_rsp_br_taken <= 1'b0;
        end else if (w_capture) begin
            r_rsp_data     <= w_rsp_data;
            r_rsp_rd       <= r_rd;
            r_rsp_we       <= w_rsp_we;
            r_rsp_br_taken <= w_rsp_br_taken;
        end else begin
            r_rsp_data     <= r_rsp_data;
            r_rsp_rd       <= r_rsp_rd;
            r_rsp_we       <= r_rsp_we;
            r_rsp_br_taken <= r_rsp_br_taken;
        end
    end

endmodule

// File: doc/edubos5_alu_issue.md
Name: edubos5_alu_issue

Overview:
- Operand-issue and result-capture stage wrapped around the eduBOS5 ALU (RV32I).
- Accepts one decoded ALU, branch or JALR request over a valid/ready handshake.
- Drives the ALU operand and control inputs, waits the ALU's registered latency, then captures the ALU result and comparison flags.
- Resolves branch taken/not-taken and presents a writeback response over a second valid/ready handshake. Sits between the decode stage and writeback/fetch-redirect.

Parameters:
ALU_LAT, 1, ALU clock-edges from operand drive to valid alu_out/eq/lt/ltu (1 for both DSP and fabric ALU builds); legal range 1..4

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid&req_ready at posedge clk
req_rs1  in  32  register operand 1
req_rs2  in  32  register operand 2
req_imm  in  32  sign-extended immediate
req_aluimm  in  1  OP-IMM instruction
req_jalr  in  1  JALR instruction
req_branch  in  1  conditional-branch instruction
req_funct3  in  3  instruction funct3
req_funct7_5  in  1  instruction bit 30
req_rd  in  5  destination register
aluin_1  out  32  to ALU operand 1
aluin_2  out  32  to ALU operand 2
shamt  out  5  to ALU shift amount
alu_funct3  out  3  to ALU funct3
alu_funct7_5  out  1  to ALU funct7_5
aluimm_dec  out  1  to ALU aluimm_dec
jalr_dec  out  1  to ALU jalr_dec
alu_out  in  32  from ALU result
eq  in  1  from ALU, operands equal
lt  in  1  from ALU, signed less-than
ltu  in  1  from ALU, unsigned less-than
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready at posedge clk
rsp_data  out  32  result / JALR target
rsp_rd  out  5  destination register
rsp_we  out  1  register write enable
rsp_br_taken  out  1  branch resolved taken

Behaviour:
- Reset (async, active-high): state=IDLE, counter=0, all operand/control/response registers 0. req_ready=0 while reset is asserted and 1 from the first cycle after release. An in-flight op is discarded with no response.
- FSM states: IDLE, EXEC, WAIT, RESP.
- IDLE: req_ready=1. On accept, latch request into op registers and go to EXEC.
- EXEC: one cycle. Op registers drive the ALU; the ALU samples operands at the end of this cycle. Load counter=ALU_LAT-1, then go to WAIT if ALU_LAT>1, else to CAPT behaviour.
- WAIT/CAPT: all ALU-facing outputs held constant from op registers. The ALU reads funct7_5, aluimm_dec and jalr_dec combinationally at its output stage, so these must not change until capture.
  - Counter decrements each cycle.
  - In the cycle where the counter reaches 0, alu_out and the flags are valid. Capture them into response registers and go to RESP.
- RESP: rsp_valid=1; all rsp_* held stable while rsp_ready=0.
  - On rsp_ready=1: if req_valid=1, accept the new request in the same cycle (req_ready=rsp_ready in RESP) and go to EXEC; otherwise go to IDLE.
- req_ready=0 in EXEC and WAIT.
- Latency: accept edge to rsp_valid=1 is ALU_LAT+1 cycles. Throughput is one op per ALU_LAT+2 cycles with rsp_ready held high.
- Operand mapping:
  - aluin_1=rs1.
  - aluin_2 = imm if (aluimm|jalr), else rs2.
  - shamt = aluimm ? imm[4:0] : rs2[4:0].
  - alu_funct7_5 = funct7_5, except 0 for JALR and 1 for branch.
  - alu_funct3 = 000 for JALR or branch, else funct3.
  - aluimm_dec=aluimm; jalr_dec=jalr.
- Branch resolution (branch=1):
  - 000 taken=eq; 001 taken=~eq.
  - 100 taken=lt; 101 taken=~lt.
  - 110 taken=ltu; 111 taken=~ltu.
  - 010/011 taken=0.
  - rsp_we=0, rsp_data=alu_out.
- JALR: rsp_data={alu_out[31:1],1'b0}, rsp_we=0 (link write handled by writeback), rsp_br_taken=0.
- ALU/OP-IMM: rsp_data=alu_out; rsp_we=1 unless rd==0; rsp_br_taken=0.
- Simultaneous branch and jalr: branch has priority; behave as branch.
- Response registers are updated only at capture, never in IDLE or RESP.
- All arithmetic is 32-bit with wrap-around; overflow is not flagged.

Test Plan:
- ADD: rs1=0x7FFF_FFFF, rs2=1, funct3=000, funct7_5=0, rd=5 → accept edge, rsp_valid 2 cycles later (ALU_LAT=1); rsp_data=0x8000_0000, rsp_we=1, rsp_rd=5.
- SRAI: rs1=0x8000_0000, imm=0x0000_0404 (imm[10]=1, shamt=4), aluimm=1, funct3=101 → rsp_data=0xF800_0000; alu_funct7_5 stays 1 through capture.
- BLT vs BLTU: rs1=0xFFFF_FFFF, rs2=1, funct3=100 → rsp_br_taken=1, rsp_we=0. Same operands with funct3=110 → rsp_br_taken=0.
- JALR: rs1=0x1000_0003, imm=4 → rsp_data=0x1000_0006, rsp_we=0. ADDI with rd=0 → rsp_we=0.
- Backpressure: rsp_ready=0 for 5 cycles → rsp_* stable, req_ready=0. Raise rsp_ready with req_valid=1 → new request accepted the same cycle and rsp_valid drops next cycle.
- Reset: assert reset while in WAIT (ALU_LAT=3) → outputs 0 immediately, no response. After release, req_ready=1 and the next op completes normally.
